aes_write_mux_n: RTL and testbench
==================================

Name: aes_write_mux_n

Overview:
Parametrised N-to-1 byte/word write mux for the iterative AES datapath. It feeds the state-register write port from NUM_IN sources. Any subset of inputs can be given a one-cycle input buffer. It adds an optional output register, a hold mode, and a precharge-to-zero mode used as a DPA countermeasure on the write bus. It also flags illegal selects and counts accepted writes, for trace alignment in attack experiments.

Parameters:
WIDTH, 8, data width of every input and of y
NUM_IN, 5, number of data inputs (>=2)
REG_MASK, 5'b00001, bit i=1 routes input i through a one-cycle input buffer; width NUM_IN
OUT_REG, 0, 1 = y/y_valid registered (+1 cycle latency); 0 = combinational output
COUNT_W, 8, width of wr_count
SEL_W, $clog2(NUM_IN), derived; must not be overridden

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous active-high reset
sel  in  SEL_W  source select
sel_valid  in  1  write request this cycle
hold  in  1  freeze output at last held value
precharge  in  1  force output to zero, suppress valid
d  in  NUM_IN*WIDTH  flattened inputs; input i = d[i*WIDTH +: WIDTH]
y  out  WIDTH  muxed write data
y_valid  out  1  y is a write beat
sel_err  out  1  sticky: out-of-range select seen
wr_count  out  COUNT_W  number of valid write beats, wraps

Behaviour:
- Input buffers: for each i with REG_MASK[i]=1, buf_i <= d_i every cycle. rst -> 0. src_i = buf_i if masked, else d_i.
- Select: sel < NUM_IN -> src_sel. sel >= NUM_IN -> src_(NUM_IN-1), matching the legacy default arm.
- Priority per cycle: rst > precharge > hold > normal.
- nxt = 0 if precharge; held if hold; else selected src.
- nxt_valid = sel_valid & ~precharge. hold does not suppress valid; it repeats the held word.
- held register: captures the selected src when sel_valid & ~hold & ~precharge. rst -> 0.
- OUT_REG=0: y = nxt and y_valid = nxt_valid, combinational.
- OUT_REG=1: y <= nxt and y_valid <= nxt_valid. rst -> y=0, y_valid=0.
- Latency from d_i to y = REG_MASK[i] + OUT_REG cycles.
- sel_err: set on the clock edge where sel_valid & (sel >= NUM_IN). Cleared only by rst. Not set when sel_valid=0.
- wr_count: +1 on each edge where the visible y_valid=1. Wraps 2^COUNT_W-1 -> 0. rst -> 0.
- Reset mid-operation: all registers are zero on the following cycle. With OUT_REG=0, y still reflects the current inputs combinationally; masked inputs read as 0 for one cycle.
- Simultaneous hold and precharge: precharge wins; held is not updated.
- Elaboration: assert NUM_IN>=2, $bits(REG_MASK)==NUM_IN, WIDTH>=1.

Decomposition:
- aes_pkg holds AES_BYTE_W=8 and the write-source index constants WR_SRC_BUF, WR_SRC_SBOX, WR_SRC_MIX, WR_SRC_KEY, WR_SRC_PT (0..4), so callers drive sel symbolically.
- One sub-module, aes_write_mux_buf: a WIDTH-bit register with synchronous reset, instantiated per masked input under generate.
- Mux, hold, precharge, counter and error logic stay in the top module.

Test Plan:
- Defaults; rst=1 for 2 cycles, sel=0, sel_valid=0 -> y=8'h00, y_valid=0, sel_err=0, wr_count=0.
- d0=8'hA5 at cycle n with sel=0, sel_valid=1 -> y=8'hA5 at n+1, not at n. Then sel=2, d2=8'h3C -> y=8'h3C same cycle, y_valid=1, wr_count increments each valid cycle.
- sel=3'd7, sel_valid=1, d4=8'h5A -> y=8'h5A, sel_err=1 next cycle. sel_err stays 1 after sel returns to 1, until rst.
- sel=1, d1=8'h11, sel_valid=1; next cycle hold=1, d1=8'h22 -> y stays 8'h11, y_valid=1. hold=0 -> y=8'h22.
- precharge=1 together with hold=1, sel_valid=1, d3=8'hFF, sel=3 -> y=8'h00, y_valid=0, wr_count unchanged, held unchanged.
- OUT_REG=1, REG_MASK=0, COUNT_W=4 -> d2=8'h77 appears on y one cycle after sel=2. 16 consecutive valid beats wrap wr_count 4'hF -> 4'h0. rst mid-stream gives y=0, y_valid=0 next cycle.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES datapath constants: byte width and symbolic write-source indices
// for the state-register write mux.
package aes_pkg;

    localparam int AES_BYTE_W = 8;

    localparam logic [2:0] WR_SRC_BUF  = 3'd0;
    localparam logic [2:0] WR_SRC_SBOX = 3'd1;
    localparam logic [2:0] WR_SRC_MIX  = 3'd2;
    localparam logic [2:0] WR_SRC_KEY  = 3'd3;
    localparam logic [2:0] WR_SRC_PT   = 3'd4;

endpackage

// File: rtl/aes_write_mux_buf.sv
// One-cycle input buffer for a write-mux source; synchronous reset to zero.
// Latency 1 cycle, free-running capture, no backpressure.
module aes_write_mux_buf #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) q <= '0;
        else     q <= d;
    end

endmodule

// File: rtl/aes_write_mux_n.sv
// N-to-1 AES state write mux with per-input buffers, hold, precharge-to-zero,
// sticky bad-select flag and beat counter. Latency REG_MASK[i]+OUT_REG; no backpressure.
module aes_write_mux_n
    import aes_pkg::*;
#(
    parameter int                WIDTH    = AES_BYTE_W,
    parameter int                NUM_IN   = 5,
    parameter logic [NUM_IN-1:0] REG_MASK = 5'b00001,
    parameter bit                OUT_REG  = 1'b0,
    parameter int                COUNT_W  = 8,
    parameter int                SEL_W    = $clog2(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    sel_valid,
    input  logic                    hold,
    input  logic                    precharge,
    input  logic [NUM_IN*WIDTH-1:0] d,
    output logic [WIDTH-1:0]        y,
    output logic                    y_valid,
    output logic                    sel_err,
    output logic [COUNT_W-1:0]      wr_count
);

    if (NUM_IN < 2 || WIDTH < 1 || $bits(REG_MASK) != NUM_IN || SEL_W != $clog2(NUM_IN)) begin : g_bad_cfg
        $error("aes_write_mux_n: illegal parameter combination");
    end

    logic [WIDTH-1:0] src [NUM_IN];
    logic [WIDTH-1:0] sel_src;
    logic [WIDTH-1:0] held;
    logic [WIDTH-1:0] nxt;
    logic             nxt_valid;
    logic             sel_oob;

    for (genvar i = 0; i < NUM_IN; i++) begin : g_src
        if (REG_MASK[i]) begin : g_buf
            aes_write_mux_buf #(.WIDTH(WIDTH)) u_buf (
                .clk (clk),
                .rst (rst),
                .d   (d[i*WIDTH +: WIDTH]),
                .q   (src[i])
            );
        end else begin : g_direct
            assign src[i] = d[i*WIDTH +: WIDTH];
        end
    end

    assign sel_oob = (32'(sel) >= 32'(NUM_IN));

    // Out-of-range selects fall through to the last input, as the legacy default arm did.
    always_comb begin
        sel_src = src[NUM_IN-1];
        for (int i = 0; i < NUM_IN - 1; i++) begin
            if (32'(sel) == 32'(i)) sel_src = src[i];
        end
    end

    always_comb begin
        nxt_valid = sel_valid & ~precharge;
        if (precharge)  nxt = '0;
        else if (hold)  nxt = held;
        else            nxt = sel_src;
    end

    always_ff @(posedge clk) begin
        if (rst)                                   held <= '0;
        else if (sel_valid && !hold && !precharge) held <= sel_src;
    end

    if (OUT_REG) begin : g_out_reg
        always_ff @(posedge clk) begin
            if (rst) begin
                y       <= '0;
                y_valid <= 1'b0;
            end else begin
                y       <= nxt;
                y_valid <= nxt_valid;
            end
        end
    end else begin : g_out_comb
        assign y       = nxt;
        assign y_valid = nxt_valid;
    end

    always_ff @(posedge clk) begin
        if (rst)                      sel_err <= 1'b0;
        else if (sel_valid && sel_oob) sel_err <= 1'b1;
    end

    // Counts beats as seen on the output, so it lines up with y_valid in traces.
    always_ff @(posedge clk) begin
        if (rst)          wr_count <= '0;
        else if (y_valid) wr_count <= wr_count + COUNT_W'(1);
    end

endmodule

// File: tb/tb_aes_write_mux_n.sv
// Two configurations driven by shared stimulus: default (input 0 buffered, combinational
// output) and registered-output with no input buffers and a 4-bit counter.
module tb_aes_write_mux_n;
    import aes_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  sel;
    logic        sel_valid, hold, precharge;
    logic [39:0] d;

    logic [7:0]  y_a, y_b;
    logic        yv_a, yv_b, err_a, err_b;
    logic [7:0]  cnt_a;
    logic [3:0]  cnt_b;

    always #5 clk = ~clk;

    aes_write_mux_n u_dut_a (
        .clk(clk), .rst(rst), .sel(sel), .sel_valid(sel_valid), .hold(hold),
        .precharge(precharge), .d(d), .y(y_a), .y_valid(yv_a), .sel_err(err_a),
        .wr_count(cnt_a)
    );

    aes_write_mux_n #(.REG_MASK(5'b00000), .OUT_REG(1'b1), .COUNT_W(4)) u_dut_b (
        .clk(clk), .rst(rst), .sel(sel), .sel_valid(sel_valid), .hold(hold),
        .precharge(precharge), .d(d), .y(y_b), .y_valid(yv_b), .sel_err(err_b),
        .wr_count(cnt_b)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference state: what each configuration should remember between cycles.
    logic [7:0] prev_d_a [5];  // last-cycle input words, zero after a reset cycle
    logic [7:0] held_a, held_b;
    logic       e_err;
    int         beats_a, beats_b;
    logic [7:0] out_b;
    logic       outv_b;

    logic [7:0] s_ya, s_yb;
    logic       s_yva, s_yvb, s_erra;
    logic [7:0] s_cnta;

    function automatic logic [7:0] word(input logic [39:0] v, input int i);
        return v[i*8 +: 8];
    endfunction

    task automatic cycle(input logic r, input logic [2:0] s, input logic v, input logic h,
                         input logic p, input logic [39:0] dd, input bit do_chk);
        int         idx;
        logic [7:0] src_a, src_b, nxt_a, nxt_b;
        logic       nv;
        rst = r; sel = s; sel_valid = v; hold = h; precharge = p; d = dd;
        @(negedge clk);
        idx   = (int'(s) >= 5) ? 4 : int'(s);
        src_a = (idx == 0) ? prev_d_a[0] : word(dd, idx);
        src_b = word(dd, idx);
        nv    = v & ~p;
        nxt_a = p ? 8'h00 : (h ? held_a : src_a);
        nxt_b = p ? 8'h00 : (h ? held_b : src_b);
        s_ya = y_a; s_yva = yv_a; s_erra = err_a; s_cnta = cnt_a;
        s_yb = y_b; s_yvb = yv_b;
        if (do_chk) begin
            chk("y_a", 32'(y_a), 32'(nxt_a));
            chk("yv_a", 32'(yv_a), 32'(nv));
            chk("err_a", 32'(err_a), 32'(e_err));
            chk("cnt_a", 32'(cnt_a), 32'(beats_a % 256));
            chk("y_b", 32'(y_b), 32'(out_b));
            chk("yv_b", 32'(yv_b), 32'(outv_b));
            chk("err_b", 32'(err_b), 32'(e_err));
            chk("cnt_b", 32'(cnt_b), 32'(beats_b % 16));
        end
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < 5; i++) prev_d_a[i] = 8'h00;
            held_a = 8'h00; held_b = 8'h00; e_err = 1'b0;
            beats_a = 0; beats_b = 0; out_b = 8'h00; outv_b = 1'b0;
        end else begin
            for (int i = 0; i < 5; i++) prev_d_a[i] = word(dd, i);
            if (v && !h && !p) begin
                held_a = src_a;
                held_b = src_b;
            end
            if (v && int'(s) >= 5) e_err = 1'b1;
            if (nv) beats_a++;
            if (outv_b) beats_b++;
            out_b  = nxt_b;
            outv_b = nv;
        end
        #1;
    endtask

    function automatic logic [39:0] put(input logic [39:0] base, input int i, input logic [7:0] w);
        logic [39:0] t;
        t = base;
        t[i*8 +: 8] = w;
        return t;
    endfunction

    initial begin
        for (int i = 0; i < 5; i++) prev_d_a[i] = 8'h00;
        held_a = 0; held_b = 0; e_err = 0; beats_a = 0; beats_b = 0; out_b = 0; outv_b = 0;

        cycle(1, WR_SRC_BUF, 0, 0, 0, 40'h0, 1'b0);
        cycle(1, WR_SRC_BUF, 0, 0, 0, 40'h0, 1'b1);
        chk("rst_y", 32'(s_ya), 32'h00);
        chk("rst_yv", 32'(s_yva), 32'h0);
        chk("rst_err", 32'(s_erra), 32'h0);
        chk("rst_cnt", 32'(s_cnta), 32'h00);

        // Buffered input 0: word shows one cycle late.
        cycle(0, WR_SRC_BUF, 1, 0, 0, put(40'h0, 0, 8'hA5), 1'b1);
        chk("buf_not_early", 32'(s_ya), 32'h00);
        cycle(0, WR_SRC_BUF, 1, 0, 0, 40'h0, 1'b1);
        chk("buf_late", 32'(s_ya), 32'hA5);
        cycle(0, WR_SRC_MIX, 1, 0, 0, put(40'h0, 2, 8'h3C), 1'b1);
        chk("direct_y", 32'(s_ya), 32'h3C);
        chk("direct_cnt", 32'(s_cnta), 32'h02);

        // Out-of-range select falls to input 4 and latches the error.
        cycle(0, 3'd7, 1, 0, 0, put(40'h0, 4, 8'h5A), 1'b1);
        chk("oob_y", 32'(s_ya), 32'h5A);
        cycle(0, WR_SRC_SBOX, 1, 0, 0, put(40'h0, 1, 8'h11), 1'b1);
        chk("oob_err", 32'(s_erra), 32'h1);
        cycle(0, WR_SRC_SBOX, 1, 1, 0, put(40'h0, 1, 8'h22), 1'b1);
        chk("hold_y", 32'(s_ya), 32'h11);
        chk("hold_yv", 32'(s_yva), 32'h1);
        chk("err_sticky", 32'(s_erra), 32'h1);
        cycle(0, WR_SRC_SBOX, 1, 0, 0, put(40'h0, 1, 8'h22), 1'b1);
        chk("unhold_y", 32'(s_ya), 32'h22);

        // Precharge beats hold and leaves held untouched.
        cycle(0, WR_SRC_KEY, 1, 1, 1, put(40'h0, 3, 8'hFF), 1'b1);
        chk("pre_y", 32'(s_ya), 32'h00);
        chk("pre_yv", 32'(s_yva), 32'h0);
        cycle(0, WR_SRC_KEY, 1, 1, 0, put(40'h0, 3, 8'hFF), 1'b1);
        chk("pre_held", 32'(s_ya), 32'h22);

        // Registered config: d2 visible one cycle after select; long valid run wraps counter.
        cycle(0, WR_SRC_MIX, 1, 0, 0, put(40'h0, 2, 8'h77), 1'b1);
        cycle(0, WR_SRC_MIX, 1, 0, 0, 40'h0, 1'b1);
        chk("oreg_y", 32'(s_yb), 32'h77);
        chk("oreg_yv", 32'(s_yvb), 32'h1);
        for (int k = 0; k < 20; k++)
            cycle(0, 3'($urandom_range(0, 4)), 1, 0, 0, {$urandom, 8'($urandom)}, 1'b1);
        cycle(1, WR_SRC_PT, 1, 0, 0, 40'hFF_FFFF_FFFF, 1'b1);
        cycle(0, WR_SRC_PT, 0, 0, 0, 40'h0, 1'b1);
        chk("midrst_yb", 32'(s_yb), 32'h00);
        chk("midrst_yvb", 32'(s_yvb), 32'h0);

        for (int k = 0; k < 400; k++) begin
            cycle(($urandom_range(0, 24) == 0), 3'($urandom_range(0, 7)),
                  ($urandom_range(0, 3) != 0), ($urandom_range(0, 4) == 0),
                  ($urandom_range(0, 7) == 0), {$urandom, 8'($urandom)}, 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
